// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline run/step/halt sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_pkg;

  // Sequencer states; 3-bit encoding keeps the state register small and explicit.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4,
    CLEAR  = 3'd5
  } runState_t;

  // Host command encodings; 5-7 fall through as NOP.
  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_RUN   = 3'd1;
  localparam logic [2:0] CMD_STEP  = 3'd2;
  localparam logic [2:0] CMD_STOP  = 3'd3;
  localparam logic [2:0] CMD_CLEAR = 3'd4;

  // Opcode field value (instruction[31:26]) that marks a HALT instruction.
  localparam logic [5:0] HALT_OPCODE_DEFAULT = 6'h3F;

endpackage

// File: rtl/pipeline_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count updates one cycle after inc/clr.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Clear wins over increment; increment stops at the all-ones ceiling.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run/step/halt sequencer: owns pipeline enable, IF squash after HALT, PC clear and cycle count.
// Latency: outputs decode the state register; an accepted command takes effect the next cycle.
// Backpressure: cmd_ready is low in DRAIN and CLEAR; accepted but illegal commands are dropped.
module pipeline_run_ctrl
  import pipeline_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter int          STEP_W       = 16,
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [5:0]  HALT_OPCODE  = HALT_OPCODE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [STEP_W-1:0] step_count,
  input  logic [5:0]        if_opcode,
  output logic              pipe_en,
  output logic              if_bubble,
  output logic              pc_clear,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  cycle_count
);

  // Drain counter only needs to hold DRAIN_CYCLES.
  localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  runState_t          state;
  logic [STEP_W-1:0]  stepRem;
  logic [DRAIN_W-1:0] drainCnt;
  logic               cmdAccept;
  logic               haltSeen;
  logic               stopCmd;

  assign cmdAccept = cmd_valid && cmd_ready;
  assign haltSeen  = (if_opcode == HALT_OPCODE);
  assign stopCmd   = cmdAccept && (cmd_op == CMD_STOP);

  // Moore decodes of the state register: no path from cmd_* to pipe_en.
  assign cmd_ready = (state == IDLE) || (state == RUN) || (state == STEP) || (state == HALTED);
  assign pipe_en   = (state == RUN) || (state == STEP) || (state == DRAIN);
  assign if_bubble = (state == DRAIN);
  assign pc_clear  = (state == CLEAR);
  assign halted    = (state == HALTED);
  assign busy      = (state == RUN) || (state == STEP) || (state == DRAIN) || (state == CLEAR);

  // Sequencer FSM with step and drain down-counters; HALT beats STOP beats step expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      stepRem  <= '0;
      drainCnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmdAccept) begin
            case (cmd_op)
              CMD_RUN:   state <= RUN;
              CMD_STEP: begin
                state   <= STEP;
                stepRem <= (step_count == '0) ? STEP_W'(1) : step_count;
              end
              CMD_CLEAR: state <= CLEAR;
              default:   state <= IDLE;
            endcase
          end
        end

        RUN: begin
          if (haltSeen) begin
            drainCnt <= DRAIN_W'(DRAIN_CYCLES);
            state    <= (DRAIN_CYCLES == 0) ? HALTED : DRAIN;
          end else if (stopCmd) begin
            state <= IDLE;
          end
        end

        STEP: begin
          if (stepRem != '0) begin
            stepRem <= stepRem - STEP_W'(1);
          end
          if (haltSeen) begin
            drainCnt <= DRAIN_W'(DRAIN_CYCLES);
            state    <= (DRAIN_CYCLES == 0) ? HALTED : DRAIN;
          end else if (stopCmd) begin
            state <= IDLE;
          end else if (stepRem <= STEP_W'(1)) begin
            state <= IDLE;
          end
        end

        DRAIN: begin
          if (drainCnt != '0) begin
            drainCnt <= drainCnt - DRAIN_W'(1);
          end
          if (drainCnt <= DRAIN_W'(1)) begin
            state <= HALTED;
          end
        end

        HALTED: begin
          if (cmdAccept && (cmd_op == CMD_CLEAR)) begin
            state <= CLEAR;
          end
        end

        CLEAR: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) uCycleCount (
    .clk   (clk),
    .reset (reset),
    .inc   (pipe_en),
    .clr   (pc_clear),
    .count (cycle_count)
  );

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed self-checking bench for pipeline_run_ctrl (CNT_W=4 to reach saturation quickly).
// Latency: inputs driven and outputs sampled 1ns after each rising edge.
// Backpressure: commands are only offered when the bench expects cmd_ready high.
module tb_pipeline_run_ctrl;

  localparam int CNT_W  = 4;
  localparam int STEP_W = 16;
  localparam logic [2:0] OP_RUN   = 3'd1;
  localparam logic [2:0] OP_STEP  = 3'd2;
  localparam logic [2:0] OP_STOP  = 3'd3;
  localparam logic [2:0] OP_CLEAR = 3'd4;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [STEP_W-1:0] step_count;
  logic [5:0]        if_opcode;
  logic              pipe_en;
  logic              if_bubble;
  logic              pc_clear;
  logic              busy;
  logic              halted;
  logic [CNT_W-1:0]  cycle_count;

  int nTests = 0;
  int nFail  = 0;

  pipeline_run_ctrl #(
    .CNT_W       (CNT_W),
    .STEP_W      (STEP_W),
    .DRAIN_CYCLES(4),
    .HALT_OPCODE (6'h3F)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .step_count (step_count),
    .if_opcode  (if_opcode),
    .pipe_en    (pipe_en),
    .if_bubble  (if_bubble),
    .pc_clear   (pc_clear),
    .busy       (busy),
    .halted     (halted),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    step_count = '0;
    if_opcode = 6'h00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Offer one command for one edge; bench only calls this when cmd_ready is expected high.
  task automatic send(input logic [2:0] op, input logic [STEP_W-1:0] cnt);
    cmd_valid = 1'b1;
    cmd_op = op;
    step_count = cnt;
    tick();
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
  endtask

  task automatic test_reset();
    doReset();
    for (int i = 0; i < 10; i++) begin
      nTests++;
      if (pipe_en !== 1'b0 || cycle_count !== 4'd0 || cmd_ready !== 1'b1 || halted !== 1'b0) begin
        nFail++;
        $display("FAIL reset_idle[%0d] got en=%b cnt=%0d rdy=%b halted=%b exp en=0 cnt=0 rdy=1 halted=0",
                 i, pipe_en, cycle_count, cmd_ready, halted);
      end
      tick();
    end
  endtask

  task automatic test_step();
    doReset();
    send(OP_STEP, 16'd3);
    for (int i = 0; i < 6; i++) begin
      nTests++;
      if (pipe_en !== (i < 3)) begin
        nFail++;
        $display("FAIL step3_en[%0d] got %b exp %b", i, pipe_en, (i < 3));
      end
      tick();
    end
    nTests++;
    if (cycle_count !== 4'd3) begin
      nFail++;
      $display("FAIL step3_count got %0d exp 3", cycle_count);
    end
    send(OP_STEP, 16'd0);
    for (int i = 0; i < 4; i++) begin
      nTests++;
      if (pipe_en !== (i < 1)) begin
        nFail++;
        $display("FAIL step0_en[%0d] got %b exp %b", i, pipe_en, (i < 1));
      end
      tick();
    end
    nTests++;
    if (cycle_count !== 4'd4 || busy !== 1'b0) begin
      nFail++;
      $display("FAIL step0_count got cnt=%0d busy=%b exp cnt=4 busy=0", cycle_count, busy);
    end
  endtask

  task automatic test_run_stop();
    doReset();
    send(OP_RUN, '0);
    for (int i = 0; i < 5; i++) begin
      nTests++;
      if (pipe_en !== 1'b1 || busy !== 1'b1) begin
        nFail++;
        $display("FAIL run_en[%0d] got en=%b busy=%b exp 1 1", i, pipe_en, busy);
      end
      if (i < 4) tick();
    end
    // Dropped in RUN: CLEAR must not leave RUN nor pulse pc_clear.
    send(OP_CLEAR, '0);
    nTests++;
    if (pipe_en !== 1'b1 || pc_clear !== 1'b0) begin
      nFail++;
      $display("FAIL run_drop_clear got en=%b pc_clear=%b exp en=1 pc_clear=0", pipe_en, pc_clear);
    end
    send(OP_STOP, '0);
    nTests++;
    if (pipe_en !== 1'b0 || cycle_count !== 4'd6 || busy !== 1'b0) begin
      nFail++;
      $display("FAIL run_stop got en=%b cnt=%0d busy=%b exp en=0 cnt=6 busy=0", pipe_en, cycle_count, busy);
    end
  endtask

  task automatic test_halt_run();
    doReset();
    send(OP_RUN, '0);
    if_opcode = 6'h3F;
    tick();
    if_opcode = 6'h00;
    for (int i = 0; i < 4; i++) begin
      nTests++;
      if (pipe_en !== 1'b1 || if_bubble !== 1'b1 || cmd_ready !== 1'b0 || halted !== 1'b0) begin
        nFail++;
        $display("FAIL drain[%0d] got en=%b bub=%b rdy=%b halted=%b exp 1 1 0 0",
                 i, pipe_en, if_bubble, cmd_ready, halted);
      end
      tick();
    end
    nTests++;
    if (halted !== 1'b1 || pipe_en !== 1'b0 || if_bubble !== 1'b0 || cmd_ready !== 1'b1 || cycle_count !== 4'd5) begin
      nFail++;
      $display("FAIL halted got halted=%b en=%b bub=%b rdy=%b cnt=%0d exp 1 0 0 1 5",
               halted, pipe_en, if_bubble, cmd_ready, cycle_count);
    end
    send(OP_RUN, '0);
    nTests++;
    if (halted !== 1'b1 || pipe_en !== 1'b0) begin
      nFail++;
      $display("FAIL halted_drop_run got halted=%b en=%b exp 1 0", halted, pipe_en);
    end
    send(OP_CLEAR, '0);
    nTests++;
    if (pc_clear !== 1'b1 || pipe_en !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0 || cycle_count !== 4'd5) begin
      nFail++;
      $display("FAIL clear_cycle got pcc=%b en=%b busy=%b rdy=%b cnt=%0d exp 1 0 1 0 5",
               pc_clear, pipe_en, busy, cmd_ready, cycle_count);
    end
    tick();
    nTests++;
    if (pc_clear !== 1'b0 || cycle_count !== 4'd0 || busy !== 1'b0 || halted !== 1'b0 || cmd_ready !== 1'b1) begin
      nFail++;
      $display("FAIL clear_exit got pcc=%b cnt=%0d busy=%b halted=%b rdy=%b exp 0 0 0 0 1",
               pc_clear, cycle_count, busy, halted, cmd_ready);
    end
  endtask

  task automatic test_halt_priority();
    // HALT together with STOP: DRAIN wins.
    doReset();
    send(OP_RUN, '0);
    if_opcode = 6'h3F;
    send(OP_STOP, '0);
    if_opcode = 6'h00;
    nTests++;
    if (if_bubble !== 1'b1 || pipe_en !== 1'b1) begin
      nFail++;
      $display("FAIL halt_vs_stop got bub=%b en=%b exp 1 1", if_bubble, pipe_en);
    end
    // Reset in the middle of DRAIN.
    tick();
    reset = 1'b1;
    tick();
    nTests++;
    if (pipe_en !== 1'b0 || if_bubble !== 1'b0 || pc_clear !== 1'b0 || busy !== 1'b0 ||
        halted !== 1'b0 || cycle_count !== 4'd0 || cmd_ready !== 1'b1) begin
      nFail++;
      $display("FAIL reset_in_drain got en=%b bub=%b pcc=%b busy=%b halted=%b cnt=%0d rdy=%b exp 0 0 0 0 0 0 1",
               pipe_en, if_bubble, pc_clear, busy, halted, cycle_count, cmd_ready);
    end
    reset = 1'b0;
    // HALT on the last STEP cycle: DRAIN, not IDLE.
    send(OP_STEP, 16'd2);
    tick();
    if_opcode = 6'h3F;
    tick();
    if_opcode = 6'h00;
    nTests++;
    if (if_bubble !== 1'b1 || pipe_en !== 1'b1 || busy !== 1'b1) begin
      nFail++;
      $display("FAIL halt_vs_expiry got bub=%b en=%b busy=%b exp 1 1 1", if_bubble, pipe_en, busy);
    end
    repeat (4) tick();
    nTests++;
    if (halted !== 1'b1 || cycle_count !== 4'd6) begin
      nFail++;
      $display("FAIL step_halt_done got halted=%b cnt=%0d exp 1 6", halted, cycle_count);
    end
  endtask

  task automatic test_saturation();
    doReset();
    send(OP_RUN, '0);
    repeat (20) tick();
    nTests++;
    if (cycle_count !== 4'd15 || pipe_en !== 1'b1) begin
      nFail++;
      $display("FAIL saturate got cnt=%0d en=%b exp 15 1", cycle_count, pipe_en);
    end
    send(OP_STOP, '0);
    nTests++;
    if (cycle_count !== 4'd15 || pipe_en !== 1'b0) begin
      nFail++;
      $display("FAIL sat_stop got cnt=%0d en=%b exp 15 0", cycle_count, pipe_en);
    end
    send(OP_CLEAR, '0);
    nTests++;
    if (pc_clear !== 1'b1 || pipe_en !== 1'b0) begin
      nFail++;
      $display("FAIL idle_clear got pcc=%b en=%b exp 1 0", pc_clear, pipe_en);
    end
    tick();
    nTests++;
    if (pc_clear !== 1'b0 || cycle_count !== 4'd0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      nFail++;
      $display("FAIL idle_clear_exit got pcc=%b cnt=%0d busy=%b rdy=%b exp 0 0 0 1",
               pc_clear, cycle_count, busy, cmd_ready);
    end
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    step_count = '0;
    if_opcode = 6'h00;
    test_reset();
    test_step();
    test_run_stop();
    test_halt_run();
    test_halt_priority();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/pipeline_run_ctrl.md
Name: pipeline_run_ctrl

Overview:
Run/step/halt sequencer for the five-stage MIPS datapath (StageIF…StageWB). It owns the global pipeline enable and the IF squash that empties the pipeline after a HALT instruction. It also drives the PC clear and counts executed cycles. Commands arrive from the debug/host side over a valid/ready handshake.

Parameters:
CNT_W, 32, width of cycle_count
STEP_W, 16, width of step_count
DRAIN_CYCLES, 4, enabled cycles after HALT fetch so that older instructions reach WB
HALT_OPCODE, 6'h3F, opcode (instruction[31:26]) treated as HALT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge
cmd_op  in  3  0 NOP, 1 RUN, 2 STEP, 3 STOP, 4 CLEAR; 5-7 treated as NOP
step_count  in  STEP_W  cycles to execute for STEP; sampled on acceptance
if_opcode  in  6  opcode of the instruction currently in IF
pipe_en  out  1  pipeline/PC advance enable
if_bubble  out  1  replaces the fetched instruction with NOP into ID
pc_clear  out  1  one-cycle PC and pipeline-register clear
busy  out  1  high in RUN, STEP, DRAIN, CLEAR
halted  out  1  HALT instruction fully drained
cycle_count  out  CNT_W  count of pipe_en=1 cycles, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: state IDLE, pipe_en 0, if_bubble 0, pc_clear 0, busy 0, halted 0, cycle_count 0, step counter 0, drain counter 0. Reset takes effect in any state, including mid-DRAIN or mid-STEP.
- Output decode: all outputs are Moore decodes of registered state, so there is no combinational path from cmd_* to pipe_en.
  - pipe_en = 1 in RUN, STEP, DRAIN.
  - if_bubble = 1 only in DRAIN.
  - pc_clear = 1 only in CLEAR.
  - halted = 1 only in HALTED.
- Handshake: cmd_ready = 1 in IDLE, RUN, STEP, HALTED; cmd_ready = 0 in DRAIN and CLEAR. A command that is accepted but illegal in the current state is consumed and dropped, with no state change.
- IDLE:
  - RUN → RUN.
  - STEP → STEP, with remaining = step_count, or 1 if step_count == 0.
  - CLEAR → CLEAR.
  - STOP and NOP are dropped.
- RUN: STOP → IDLE. RUN, STEP and CLEAR are dropped.
- STEP:
  - Each cycle, remaining decrements.
  - When remaining == 1 → IDLE, so exactly N enabled cycles execute.
  - STOP → IDLE. Other commands are dropped.
- HALT detect: in RUN or STEP, if_opcode == HALT_OPCODE → DRAIN, with drain counter = DRAIN_CYCLES.
  - Priority is HALT > STOP > step expiry.
  - The HALT instruction itself is fetched in the detect cycle.
- DRAIN:
  - Each cycle, the drain counter decrements.
  - When the counter == 1 → HALTED. Exactly DRAIN_CYCLES cycles run with pipe_en = 1 and if_bubble = 1.
  - If DRAIN_CYCLES == 0, go directly to HALTED.
- HALTED: only CLEAR is honoured (→ CLEAR). All other commands are dropped.
- CLEAR: lasts exactly one cycle with pc_clear = 1, pipe_en = 0. It zeroes cycle_count at the exit edge, then → IDLE.
- cycle_count:
  - +1 on every cycle with pipe_en = 1.
  - Holds at 2^CNT_W − 1; no wrap.
  - Cleared only by reset or CLEAR.
- Step and drain counters: unsigned arithmetic, never decrement below 0.

Decomposition:
- Shared package (pipeline_pkg):
  - state enum IDLE/RUN/STEP/DRAIN/HALTED/CLEAR (3-bit encoding);
  - CMD_NOP/RUN/STEP/STOP/CLEAR constants;
  - HALT_OPCODE default.
- One sub-module, sat_counter (parametric width, inc, clr, synchronous reset), used for cycle_count.
- The FSM and the step/drain down-counters stay in pipeline_run_ctrl.

Test Plan:
- Reset then idle:
  - hold reset 2 cycles, then cmd_valid = 0 for 10 cycles → pipe_en = 0, cycle_count = 0, cmd_ready = 1, halted = 0 throughout.
- STEP 3:
  - accept STEP with step_count = 3 → pipe_en = 1 for exactly 3 cycles, then IDLE; cycle_count = 3.
  - step_count = 0 → exactly 1 enabled cycle.
- RUN then STOP:
  - RUN accepted at cycle t, STOP accepted at t+5 → pipe_en high for cycles t+1..t+5 only; cycle_count = 5.
- HALT during RUN, DRAIN_CYCLES = 4:
  - if_opcode = 6'h3F at cycle h → if_bubble = 1 and pipe_en = 1 for h+1..h+4;
  - halted = 1 from h+5; cmd_ready = 0 in h+1..h+4;
  - RUN offered in HALTED is dropped.
- HALT vs STOP/step expiry:
  - HALT opcode together with STOP, or on the last STEP cycle → DRAIN, not IDLE.
  - Reset asserted in DRAIN → IDLE next cycle with all outputs at reset values.
- CLEAR and saturation:
  - with CNT_W = 4, RUN for 20 cycles → cycle_count holds at 15.
  - STOP, then CLEAR → pc_clear high for 1 cycle, cycle_count = 0, state IDLE.
